// File: rtl/tech_regfile_pkg.sv
// Shared types and helpers for the multi-port tech regfile.
package tech_regfile_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned MAX_RD_PORTS  = 8;
  localparam int unsigned MAX_BIT_WIDTH = 1024;
  localparam int unsigned MAX_BM_WIDTH  = MAX_BIT_WIDTH / 8;

  // Widen a per-byte mask to a per-bit mask; callers truncate to their width.
  function automatic logic [MAX_BIT_WIDTH-1:0] expand_bm(input logic [MAX_BM_WIDTH-1:0] bm);
    logic [MAX_BIT_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BM_WIDTH; i++) begin
      m[i*8 +: 8] = {8{bm[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tech_regfile_rdport.sv
// One registered read port: range check, optional write bypass, output regs.
// Optional feature macro: TECH_REGFILE_MP_BYPASS_EN (write-first collisions).
module tech_regfile_rdport #(
  parameter int BIT_WIDTH  = 128,
  parameter int WORD_DEPTH = 64,
  parameter int AW         = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic                 ren,
  input  logic [AW-1:0]        raddr,
  input  logic [BIT_WIDTH-1:0] mem_word,
`ifdef TECH_REGFILE_MP_BYPASS_EN
  input  logic                 wr_en,
  input  logic [AW-1:0]        waddr,
  input  logic [BIT_WIDTH-1:0] wr_word,
`endif
  output logic [BIT_WIDTH-1:0] rdat,
  output logic                 rerr
);

  localparam int AWP1 = AW + 1;
  localparam logic [AW:0] DEPTH_W = AWP1'(WORD_DEPTH);

  logic                 in_range;
  logic [BIT_WIDTH-1:0] sel_word;

  assign in_range = {1'b0, raddr} < DEPTH_W;

`ifdef TECH_REGFILE_MP_BYPASS_EN
  assign sel_word = (wr_en && (waddr == raddr)) ? wr_word : mem_word;
`else
  assign sel_word = mem_word;
`endif

  // Capture read data or out-of-range flag; hold when idle or not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdat <= '0;
      rerr <= 1'b0;
    end else if (ready && ren) begin
      if (in_range) begin
        rdat <= sel_word;
        rerr <= 1'b0;
      end else begin
        rdat <= '0;
        rerr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tech_regfile_mp.sv
// Multi-read-port register file with byte-masked write and clear engine.
// Optional feature macro: TECH_REGFILE_MP_BYPASS_EN (write-first collisions).
module tech_regfile_mp
  import tech_regfile_pkg::*;
#(
  parameter  int BIT_WIDTH  = 128,
  parameter  int WORD_DEPTH = 64,
  parameter  int RD_PORTS   = 2,
  localparam int AW         = $clog2(WORD_DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  output logic                          init_done_o,
  input  logic                          wen_i,
  input  logic [AW-1:0]                 waddr_i,
  input  logic [BIT_WIDTH/8-1:0]        bm_i,
  input  logic [BIT_WIDTH-1:0]          wdat_i,
  input  logic [RD_PORTS-1:0]           ren_i,
  input  logic [RD_PORTS*AW-1:0]        raddr_i,
  output logic [RD_PORTS*BIT_WIDTH-1:0] rdat_o,
  output logic [RD_PORTS-1:0]           rerr_o
);

  localparam int AWP1 = AW + 1;
  localparam logic [AW:0]   DEPTH_W = AWP1'(WORD_DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(WORD_DEPTH - 1);

  state_t               state, state_nxt;
  logic [AW-1:0]        ptr, ptr_nxt;
  logic                 ready;
  logic                 wr_ok;
  logic [BIT_WIDTH-1:0] mask;
  logic [BIT_WIDTH-1:0] old_word;
  logic [BIT_WIDTH-1:0] merged;

  logic [BIT_WIDTH-1:0] mem [WORD_DEPTH];

  assign ready       = (state == READY);
  assign init_done_o = ready;
  assign wr_ok       = ready && wen_i && ({1'b0, waddr_i} < DEPTH_W);
  assign mask        = BIT_WIDTH'(expand_bm(MAX_BM_WIDTH'(bm_i)));
  assign old_word    = mem[waddr_i];
  assign merged      = (wdat_i & mask) | (old_word & ~mask);

  // State and sweep pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state: sweep every word once, clr_i restarts the sweep from zero.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      INIT: begin
        if (clr_i) begin
          ptr_nxt = '0;
        end else if (ptr == LAST) begin
          state_nxt = READY;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + AW'(1);
        end
      end
      READY: begin
        if (clr_i) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Storage array: sweep zeroing while initialising, masked merge when ready.
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[waddr_i] <= merged;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr_i[p*AW +: AW];

    tech_regfile_rdport #(
      .BIT_WIDTH (BIT_WIDTH),
      .WORD_DEPTH(WORD_DEPTH),
      .AW        (AW)
    ) u_rdport (
      .clk     (clk_i),
      .rst     (rst_i),
      .ready   (ready),
      .ren     (ren_i[p]),
      .raddr   (ra),
      .mem_word(mem[ra]),
`ifdef TECH_REGFILE_MP_BYPASS_EN
      .wr_en   (wr_ok),
      .waddr   (waddr_i),
      .wr_word (merged),
`endif
      .rdat    (rdat_o[p*BIT_WIDTH +: BIT_WIDTH]),
      .rerr    (rerr_o[p])
    );
  end

endmodule

// File: tb/tb_tech_regfile_mp.sv
// Directed bench for tech_regfile_mp: a 64-word and a 40-word instance.
module tb_tech_regfile_mp;

  logic         clk = 1'b0;
  logic         rst_a, rst_b, clr_a, clr_b;
  logic         sel;
  logic         wen;
  logic [5:0]   waddr;
  logic [15:0]  bm;
  logic [127:0] wdat;
  logic [1:0]   ren;
  logic [11:0]  raddr;

  logic         done_a, done_b;
  logic [255:0] rdat_a, rdat_b, rdat;
  logic [1:0]   rerr_a, rerr_b, rerr;
  logic [127:0] rd0, rd1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tech_regfile_mp #(.BIT_WIDTH(128), .WORD_DEPTH(64), .RD_PORTS(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .clr_i(clr_a), .init_done_o(done_a),
    .wen_i(wen & ~sel), .waddr_i(waddr), .bm_i(bm), .wdat_i(wdat),
    .ren_i(ren & {2{~sel}}), .raddr_i(raddr), .rdat_o(rdat_a), .rerr_o(rerr_a)
  );

  tech_regfile_mp #(.BIT_WIDTH(128), .WORD_DEPTH(40), .RD_PORTS(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .clr_i(clr_b), .init_done_o(done_b),
    .wen_i(wen & sel), .waddr_i(waddr), .bm_i(bm), .wdat_i(wdat),
    .ren_i(ren & {2{sel}}), .raddr_i(raddr), .rdat_o(rdat_b), .rerr_o(rerr_b)
  );

  assign rdat = sel ? rdat_b : rdat_a;
  assign rerr = sel ? rerr_b : rerr_a;
  assign rd0  = rdat[127:0];
  assign rd1  = rdat[255:128];

  localparam logic [127:0] D_FULL = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] D_BM   = 128'h0123456789abcdef0123456789abcdff;
  localparam logic [127:0] D_AA   = {16{8'hAA}};
  localparam logic [127:0] D_55   = {16{8'h55}};
  localparam logic [127:0] D_P    = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] m, input logic [127:0] d);
    wen = 1'b1; waddr = a; bm = m; wdat = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a0, input logic [5:0] a1);
    ren = 2'b11; raddr = {a1, a0};
    tick();
    ren = 2'b00;
  endtask

  task automatic test_reset();
    int cyc_a, cyc_b;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) tick();
    sel = 1'b0;
    n_vec++;
    if ({done_a, rerr, rdat} !== '0) begin
      n_err++; $display("FAIL reset_a: got done=%b rerr=%b rdat=%h expected all 0", done_a, rerr, rdat);
    end
    sel = 1'b1; #1;
    n_vec++;
    if ({done_b, rerr, rdat} !== '0) begin
      n_err++; $display("FAIL reset_b: got done=%b rerr=%b rdat=%h expected all 0", done_b, rerr, rdat);
    end
    sel = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    cyc_a = -1; cyc_b = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done_a && cyc_a < 0) cyc_a = c;
      if (done_b && cyc_b < 0) cyc_b = c;
      if (cyc_a >= 0 && cyc_b >= 0) break;
    end
    n_vec++;
    if (cyc_a !== 64) begin
      n_err++; $display("FAIL init_latency_a: got %0d cycles expected 64", cyc_a);
    end
    n_vec++;
    if (cyc_b !== 40) begin
      n_err++; $display("FAIL init_latency_b: got %0d cycles expected 40", cyc_b);
    end
  endtask

  task automatic test_init_zero();
    sel = 1'b0;
    for (int a = 0; a < 64; a += 2) begin
      do_read(6'(a), 6'(a + 1));
      n_vec++;
      if ({rerr, rd1, rd0} !== '0) begin
        n_err++; $display("FAIL init_zero[%0d]: got rerr=%b rd0=%h rd1=%h expected 0", a, rerr, rd0, rd1);
      end
    end
  endtask

  task automatic test_byte_mask();
    sel = 1'b0;
    do_write(6'd5, 16'hffff, D_FULL);
    do_read(6'd5, 6'd5);
    n_vec++;
    if (rd0 !== D_FULL || rd1 !== D_FULL) begin
      n_err++; $display("FAIL full_write: got %h/%h expected %h", rd0, rd1, D_FULL);
    end
    do_write(6'd5, 16'h0001, {128{1'b1}});
    do_read(6'd0, 6'd5);
    n_vec++;
    if (rd1 !== D_BM || rd0 !== '0 || rerr !== 2'b00) begin
      n_err++; $display("FAIL byte_mask: got rd1=%h rd0=%h rerr=%b expected rd1=%h rd0=0 rerr=0", rd1, rd0, rerr, D_BM);
    end
  endtask

  task automatic test_collision();
    logic [127:0] exp_c;
`ifdef TECH_REGFILE_MP_BYPASS_EN
    exp_c = D_AA;
`else
    exp_c = '0;
`endif
    sel = 1'b0;
    wen = 1'b1; waddr = 6'd9; bm = 16'hffff; wdat = D_AA;
    ren = 2'b11; raddr = {6'd9, 6'd9};
    tick();
    wen = 1'b0; ren = 2'b00;
    n_vec++;
    if (rd0 !== exp_c || rd1 !== exp_c || rerr !== 2'b00) begin
      n_err++; $display("FAIL collision: got rd0=%h rd1=%h rerr=%b expected %h", rd0, rd1, rerr, exp_c);
    end
    do_read(6'd9, 6'd9);
    n_vec++;
    if (rd0 !== D_AA || rd1 !== D_AA) begin
      n_err++; $display("FAIL after_collision: got rd0=%h rd1=%h expected %h", rd0, rd1, D_AA);
    end
  endtask

  task automatic test_out_of_range();
    logic [127:0] e0, e1;
    sel = 1'b1;
    do_write(6'd3, 16'hffff, D_P);
    do_read(6'd3, 6'd3);
    n_vec++;
    if (rd0 !== D_P || rd1 !== D_P) begin
      n_err++; $display("FAIL oor_setup: got %h/%h expected %h", rd0, rd1, D_P);
    end
    do_read(6'd45, 6'd3);
    n_vec++;
    if (rd0 !== '0 || rerr !== 2'b01 || rd1 !== D_P) begin
      n_err++; $display("FAIL oor_read: got rd0=%h rerr=%b rd1=%h expected rd0=0 rerr=01 rd1=%h", rd0, rerr, rd1, D_P);
    end
    do_read(6'd63, 6'd39);
    n_vec++;
    if (rerr !== 2'b01 || rd0 !== '0 || rd1 !== '0) begin
      n_err++; $display("FAIL oor_edge: got rerr=%b rd0=%h rd1=%h expected rerr=01 rd0=0 rd1=0", rerr, rd0, rd1);
    end
    do_write(6'd45, 16'hffff, {128{1'b1}});
    for (int a = 0; a < 40; a += 2) begin
      do_read(6'(a), 6'(a + 1));
      e0 = (a == 3) ? D_P : '0;
      e1 = (a + 1 == 3) ? D_P : '0;
      n_vec++;
      if (rd0 !== e0 || rd1 !== e1 || rerr !== 2'b00) begin
        n_err++; $display("FAIL oor_write_scan[%0d]: got rd0=%h rd1=%h rerr=%b expected %h/%h", a, rd0, rd1, rerr, e0, e1);
      end
    end
  endtask

  task automatic test_clear();
    int cyc;
    sel = 1'b1;
    for (int a = 0; a < 40; a++) do_write(6'(a), 16'hffff, D_55);
    do_read(6'd0, 6'd39);
    n_vec++;
    if (rd0 !== D_55 || rd1 !== D_55) begin
      n_err++; $display("FAIL fill: got %h/%h expected %h", rd0, rd1, D_55);
    end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    n_vec++;
    if (done_b !== 1'b0) begin
      n_err++; $display("FAIL clr_done_drop: got %b expected 0", done_b);
    end
    ren = 2'b11; raddr = {6'd45, 6'd7};
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done_b) begin cyc = c; break; end
    end
    ren = 2'b00;
    n_vec++;
    if (cyc !== 40) begin
      n_err++; $display("FAIL clr_latency: got %0d cycles expected 40", cyc);
    end
    n_vec++;
    if (rd0 !== D_55 || rd1 !== D_55 || rerr !== 2'b00) begin
      n_err++; $display("FAIL init_read_hold: got rd0=%h rd1=%h rerr=%b expected %h rerr=00", rd0, rd1, rerr, D_55);
    end
    for (int a = 0; a < 40; a += 2) begin
      do_read(6'(a), 6'(a + 1));
      n_vec++;
      if ({rerr, rd1, rd0} !== '0) begin
        n_err++; $display("FAIL clr_scan[%0d]: got rd0=%h rd1=%h rerr=%b expected 0", a, rd0, rd1, rerr);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int cyc;
    sel = 1'b0;
    do_read(6'd9, 6'd5);
    n_vec++;
    if (rd0 !== D_AA || rd1 !== D_BM) begin
      n_err++; $display("FAIL pre_midsweep: got %h/%h expected %h/%h", rd0, rd1, D_AA, D_BM);
    end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    repeat (20) tick();
    rst_a = 1'b1;
    #1;
    n_vec++;
    if ({done_a, rerr, rdat} !== '0) begin
      n_err++; $display("FAIL midsweep_reset: got done=%b rerr=%b rdat=%h expected all 0", done_a, rerr, rdat);
    end
    tick();
    rst_a = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done_a) begin cyc = c; break; end
    end
    n_vec++;
    if (cyc !== 64) begin
      n_err++; $display("FAIL midsweep_latency: got %0d cycles expected 64", cyc);
    end
    do_read(6'd9, 6'd5);
    n_vec++;
    if ({rerr, rd1, rd0} !== '0) begin
      n_err++; $display("FAIL midsweep_cleared: got rd0=%h rd1=%h expected 0", rd0, rd1);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0; sel = 1'b0;
    wen = 1'b0; waddr = '0; bm = '0; wdat = '0; ren = '0; raddr = '0;
    test_reset();
    test_init_zero();
    test_byte_mask();
    test_collision();
    test_out_of_range();
    test_clear();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
